// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA zone-detect slice:
//   - ZONE_* map colour codes recognised as interactive zones
//   - MARKER_RGB, the colour painted on the probe pixel in debug builds
//   - zone_state_t, the debounce FSM state encoding
//   - classify_zone(), which maps a captured sample onto a zone code
//------------------------------------------------------------------------------
package vga_pkg;

    localparam logic [11:0] ZONE_NONE   = 12'h000;
    localparam logic [11:0] ZONE_WOMAN  = 12'h00F;
    localparam logic [11:0] ZONE_WIZARD = 12'h0FF;
    localparam logic [11:0] ZONE_DOOR   = 12'hFF0;

    localparam logic [11:0] MARKER_RGB  = 12'hF0F;

    typedef enum logic [0:0] {
        LOCKED  = 1'b0,
        PENDING = 1'b1
    } zone_state_t;

    // Only the three known zone colours survive; anything else, or a frame
    // in which the probe pixel was never seen, reads as "no zone".
    function automatic logic [11:0] classify_zone(input logic        valid,
                                                  input logic [11:0] rgb);
        if (!valid) begin
            return ZONE_NONE;
        end
        case (rgb)
            ZONE_WOMAN, ZONE_WIZARD, ZONE_DOOR: return rgb;
            default:                            return ZONE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vga_if.sv
//------------------------------------------------------------------------------
// vga_if
// One VGA timing + colour stream.
//   vcount, hcount : 11-bit raster position
//   vsync,  hsync  : sync pulses
//   vblnk,  hblnk  : blanking flags (pixel not visible when either is set)
//   rgb            : 12-bit colour, 4 bits per channel
// Modports:
//   in  : consumer side (all fields are inputs)
//   out : producer side (all fields are outputs)
//------------------------------------------------------------------------------
interface vga_if;

    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

    modport out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

endinterface

// File: rtl/zone_debounce.sv
//------------------------------------------------------------------------------
// zone_debounce
// Per-frame debounce of the zone code under the player. A new code must be
// seen on STABLE_FRAMES consecutive evaluations before it is published on
// current_pix, at which point zone_change pulses for one clock.
//
// Parameters:
//   STABLE_FRAMES : evaluations a new code must persist (1..15)
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   eval         in   one-cycle strobe, once per frame
//   code         in   classified zone code for the frame just finished
//   current_pix  out  published (debounced) zone code
//   zone_change  out  one-cycle pulse when current_pix changes
//------------------------------------------------------------------------------
module zone_debounce
    import vga_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eval,
    input  logic [11:0] code,
    output logic [11:0] current_pix,
    output logic        zone_change
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_FRAMES);

    zone_state_t state;
    logic [11:0] candidate;
    logic [3:0]  counter;
    logic [3:0]  cnt_inc;

    // Saturating increment: the counter holds at 15 rather than wrapping.
    assign cnt_inc = (counter == 4'hF) ? counter : counter + 4'd1;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it only takes effect on a clock edge.
        if (rst) begin
            state       <= LOCKED;
            current_pix <= ZONE_NONE;
            candidate   <= 12'h000;
            counter     <= 4'd0;
            zone_change <= 1'b0;
        end else begin
            zone_change <= 1'b0;
            if (eval) begin
                case (state)
                    LOCKED: begin
                        if (code == current_pix) begin
                            counter <= 4'd0;
                        end else if (STABLE_LIM == 4'd1) begin
                            // A single stable frame is enough: skip PENDING.
                            current_pix <= code;
                            zone_change <= 1'b1;
                            counter     <= 4'd0;
                        end else begin
                            candidate <= code;
                            counter   <= 4'd1;
                            state     <= PENDING;
                        end
                    end

                    PENDING: begin
                        // candidate never equals current_pix here, so the
                        // order of the first two tests does not matter.
                        if (code == candidate) begin
                            if (cnt_inc >= STABLE_LIM) begin
                                current_pix <= candidate;
                                zone_change <= 1'b1;
                                counter     <= 4'd0;
                                state       <= LOCKED;
                            end else begin
                                counter <= cnt_inc;
                            end
                        end else if (code == current_pix) begin
                            // Glitch died out before being published.
                            counter <= 4'd0;
                            state   <= LOCKED;
                        end else begin
                            candidate <= code;
                            counter   <= 4'd1;
                        end
                    end

                    default: begin
                        counter <= 4'd0;
                        state   <= LOCKED;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/game_zone_detect.sv
//------------------------------------------------------------------------------
// game_zone_detect
// Samples the map colour under the player's probe point once per frame,
// classifies it into a zone code and debounces it across frames. The VGA
// stream passes through with a fixed one-clock delay.
//
// Optional build macro:
//   ZONE_DEBUG_MARKER_EN : paint the probe pixel MARKER_RGB on out.rgb
//
// Parameters:
//   STABLE_FRAMES : frames a new zone code must persist (1..15)
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   in           in   vga_if.in  - map stream before any overlay
//   out          out  vga_if.out - same stream, registered
//   xpos, ypos   in   player probe column / row in pixels
//   current_pix  out  debounced zone code under the player
//   zone_change  out  one-cycle pulse when current_pix changes
//------------------------------------------------------------------------------
module game_zone_detect
    import vga_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    vga_if.out          out,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [11:0] current_pix,
    output logic        zone_change
);

    logic        vsync_q;
    logic        vsync_rise;
    logic        eval_q;
    logic [10:0] probe_x;
    logic [10:0] probe_y;
    logic        probe_hit;
    logic [11:0] sample;
    logic        captured;
    logic [11:0] zone_code;

    assign vsync_rise = in.vsync & ~vsync_q;

    assign probe_hit = (in.hcount == probe_x) && (in.vcount == probe_y) &&
                       !in.hblnk && !in.vblnk;

    assign zone_code = classify_zone(captured, sample);

    //--------------------------------------------------------------------------
    // Stream pipeline: every field delayed by exactly one clock.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out.vcount <= 11'd0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= 11'd0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= 12'h000;
        end else begin
            out.vcount <= in.vcount;
            out.vsync  <= in.vsync;
            out.vblnk  <= in.vblnk;
            out.hcount <= in.hcount;
            out.hsync  <= in.hsync;
            out.hblnk  <= in.hblnk;
`ifdef ZONE_DEBUG_MARKER_EN
            out.rgb    <= probe_hit ? MARKER_RGB : in.rgb;
`else
            out.rgb    <= in.rgb;
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Probe latch and per-frame sample capture. The probe only moves at the
    // vsync rising edge, so a frame is always sampled at one fixed point.
    // The evaluation strobe lands one clock after that edge.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            eval_q   <= 1'b0;
            probe_x  <= 11'd0;
            probe_y  <= 11'd0;
            sample   <= 12'h000;
            captured <= 1'b0;
        end else begin
            vsync_q <= in.vsync;
            eval_q  <= vsync_rise;

            if (vsync_rise) begin
                probe_x <= xpos;
                probe_y <= ypos;
            end

            if (probe_hit) begin
                sample <= in.rgb;
            end

            // The evaluation consumes the flag; a hit in the same cycle
            // already belongs to the next frame.
            if (eval_q) begin
                captured <= probe_hit;
            end else if (probe_hit) begin
                captured <= 1'b1;
            end
        end
    end

    zone_debounce #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .eval        (eval_q),
        .code        (zone_code),
        .current_pix (current_pix),
        .zone_change (zone_change)
    );

endmodule

// File: tb/tb_game_zone_detect.sv
//------------------------------------------------------------------------------
// tb_game_zone_detect
// Directed bench for game_zone_detect. Each "frame" is a short burst: a decoy
// pixel, two chosen pixels, then a vsync pulse that triggers one evaluation.
// zone_change pulses are counted by a monitor so pulse width is checked too.
//------------------------------------------------------------------------------
module tb_game_zone_detect;
    import vga_pkg::*;

`ifdef ZONE_DEBUG_MARKER_EN
    localparam bit MARKER_ON = 1'b1;
`else
    localparam bit MARKER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] xpos = 11'd0;
    logic [10:0] ypos = 11'd0;
    logic [11:0] current_pix;
    logic        zone_change;

    vga_if vin ();
    vga_if vout ();

    game_zone_detect #(
        .STABLE_FRAMES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (vin.in),
        .out         (vout.out),
        .xpos        (xpos),
        .ypos        (ypos),
        .current_pix (current_pix),
        .zone_change (zone_change)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    int p0;

    always @(negedge clk) begin
        if (!rst && zone_change) pulse_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_px(input logic [10:0] h, input logic [10:0] v,
                          input logic hs, input logic vs, input logic hb,
                          input logic vb, input logic [11:0] rgb);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
    endtask

    task automatic vsync_pulse();
        tick(); set_px(11'd0, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
        tick();
        tick(); set_px(11'd0, 11'd601, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();
    endtask

    // Pixels beyond the 800x600 visible area are driven as blanked.
    task automatic frame(input logic [10:0] ha, input logic [10:0] va, input logic [11:0] rgba,
                         input logic [10:0] hb, input logic [10:0] vb, input logic [11:0] rgbb,
                         input bit chk_a);
        tick(); set_px(11'd10, 11'd10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
        tick(); set_px(ha, va, 1'b0, 1'b0, ha >= 11'd800, va >= 11'd600, rgba);
        tick();
        if (chk_a) check("probe_rgb", 16'(vout.rgb), 16'(MARKER_ON ? MARKER_RGB : rgba));
        set_px(hb, vb, 1'b0, 1'b0, hb >= 11'd800, vb >= 11'd600, rgbb);
        vsync_pulse();
    endtask

    task automatic zframe(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                          input bit chk);
        frame(h, v, rgb, 11'd500, 11'd500, 12'h123, chk);
    endtask

    initial begin
        set_px(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) tick();
        check("rst_out_rgb",    16'(vout.rgb), 16'h0000);
        check("rst_out_hcount", 16'(vout.hcount), 16'h0000);
        check("rst_current",    16'(current_pix), 16'(ZONE_NONE));
        check("rst_zone_change",16'(zone_change), 16'h0000);
        check("rst_state",      16'(dut.u_debounce.state), 16'(LOCKED));
        rst = 1'b0;

        // ---------------- one-clock pipeline ----------------
        tick(); set_px(11'd5, 11'd7, 1'b1, 1'b0, 1'b1, 1'b0, 12'hABC);
        tick();
        check("pipe_hcount", 16'(vout.hcount), 16'd5);
        check("pipe_vcount", 16'(vout.vcount), 16'd7);
        check("pipe_hsync",  16'(vout.hsync),  16'd1);
        check("pipe_hblnk",  16'(vout.hblnk),  16'd1);
        check("pipe_vblnk",  16'(vout.vblnk),  16'd0);
        check("pipe_rgb",    16'(vout.rgb),    16'hABC);
        set_px(11'd6, 11'd7, 1'b0, 1'b1, 1'b0, 1'b1, 12'h321);
        tick();
        check("pipe_vsync",  16'(vout.vsync),  16'd1);
        check("pipe_rgb2",   16'(vout.rgb),    16'h321);
        set_px(11'd0, 11'd601, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();

        // ---------------- wizard x3 then none: no publish ----------------
        xpos = 11'd100; ypos = 11'd200;
        vsync_pulse();
        p0 = pulse_cnt;
        repeat (3) zframe(11'd100, 11'd200, ZONE_WIZARD, 1'b1);
        check("wiz3_state",   16'(dut.u_debounce.state),   16'(PENDING));
        check("wiz3_counter", 16'(dut.u_debounce.counter), 16'd3);
        check("wiz3_current", 16'(current_pix), 16'(ZONE_NONE));
        zframe(11'd100, 11'd200, 12'h000, 1'b0);
        check("wiz_back_state",   16'(dut.u_debounce.state),   16'(LOCKED));
        check("wiz_back_counter", 16'(dut.u_debounce.counter), 16'd0);
        check("wiz_back_current", 16'(current_pix), 16'(ZONE_NONE));
        check("wiz_back_pulses",  16'(pulse_cnt - p0), 16'd0);

        // ---------------- alternating door/wizard ----------------
        p0 = pulse_cnt;
        repeat (3) begin
            zframe(11'd100, 11'd200, ZONE_DOOR, 1'b0);
            zframe(11'd100, 11'd200, ZONE_WIZARD, 1'b0);
        end
        check("alt_current",   16'(current_pix), 16'(ZONE_NONE));
        check("alt_candidate", 16'(dut.u_debounce.candidate), 16'(ZONE_WIZARD));
        check("alt_counter",   16'(dut.u_debounce.counter), 16'd1);
        check("alt_pulses",    16'(pulse_cnt - p0), 16'd0);

        // ---------------- woman x4: publish after 4th ----------------
        p0 = pulse_cnt;
        repeat (3) zframe(11'd100, 11'd200, ZONE_WOMAN, 1'b0);
        check("woman3_current", 16'(current_pix), 16'(ZONE_NONE));
        zframe(11'd100, 11'd200, ZONE_WOMAN, 1'b0);
        check("woman4_current", 16'(current_pix), 16'(ZONE_WOMAN));
        check("woman4_pulses",  16'(pulse_cnt - p0), 16'd1);
        check("woman4_state",   16'(dut.u_debounce.state), 16'(LOCKED));

        // ---------------- lock wizard ----------------
        p0 = pulse_cnt;
        repeat (3) zframe(11'd100, 11'd200, ZONE_WIZARD, 1'b0);
        check("lockwiz3_current", 16'(current_pix), 16'(ZONE_WOMAN));
        zframe(11'd100, 11'd200, ZONE_WIZARD, 1'b0);
        check("lockwiz4_current", 16'(current_pix), 16'(ZONE_WIZARD));
        check("lockwiz4_pulses",  16'(pulse_cnt - p0), 16'd1);

        // ---------------- off-screen probe returns to none ----------------
        xpos = 11'd900; ypos = 11'd900;
        p0 = pulse_cnt;
        repeat (3) zframe(11'd900, 11'd900, ZONE_WIZARD, 1'b0);
        check("off3_current", 16'(current_pix), 16'(ZONE_WIZARD));
        zframe(11'd900, 11'd900, ZONE_WIZARD, 1'b0);
        check("off4_current", 16'(current_pix), 16'(ZONE_NONE));
        check("off4_pulses",  16'(pulse_cnt - p0), 16'd1);

        // ---------------- xpos moved mid-frame ----------------
        xpos = 11'd100; ypos = 11'd200;
        vsync_pulse();
        tick(); set_px(11'd20, 11'd20, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
        xpos = 11'd300;
        frame(11'd100, 11'd200, ZONE_DOOR, 11'd300, 11'd200, ZONE_WIZARD, 1'b1);
        check("mid_old_probe", 16'(dut.u_debounce.candidate), 16'(ZONE_DOOR));
        frame(11'd100, 11'd200, ZONE_DOOR, 11'd300, 11'd200, ZONE_WIZARD, 1'b0);
        check("mid_new_probe", 16'(dut.u_debounce.candidate), 16'(ZONE_WIZARD));

        // ---------------- reset during PENDING at counter 3 ----------------
        repeat (2) frame(11'd300, 11'd200, ZONE_WIZARD, 11'd500, 11'd500, 12'h123, 1'b1);
        check("pre_rst_counter", 16'(dut.u_debounce.counter), 16'd3);
        check("pre_rst_state",   16'(dut.u_debounce.state),   16'(PENDING));
        p0 = pulse_cnt;
        tick(); set_px(11'd300, 11'd200, 1'b0, 1'b0, 1'b0, 1'b0, ZONE_WIZARD);
        tick(); rst = 1'b1; set_px(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick(); tick();
        check("mrst_current",   16'(current_pix), 16'(ZONE_NONE));
        check("mrst_change",    16'(zone_change), 16'd0);
        check("mrst_state",     16'(dut.u_debounce.state), 16'(LOCKED));
        check("mrst_counter",   16'(dut.u_debounce.counter), 16'd0);
        check("mrst_candidate", 16'(dut.u_debounce.candidate), 16'h000);
        check("mrst_captured",  16'(dut.captured), 16'd0);
        check("mrst_out_rgb",   16'(vout.rgb), 16'h000);
        rst = 1'b0;
        vsync_pulse();
        check("post_rst_current", 16'(current_pix), 16'(ZONE_NONE));
        repeat (3) zframe(11'd300, 11'd200, ZONE_WIZARD, 1'b1);
        check("post_rst3_current", 16'(current_pix), 16'(ZONE_NONE));
        zframe(11'd300, 11'd200, ZONE_WIZARD, 1'b1);
        check("post_rst4_current", 16'(current_pix), 16'(ZONE_WIZARD));
        check("post_rst_pulses",   16'(pulse_cnt - p0), 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/game_zone_detect.md
GAME_ZONE_DETECT -- requirements
Module: game_zone_detect

Interface
REQ-001 Parameter STABLE_FRAMES, default 4, frames a new zone code must persist before it is published (range 1..15).
REQ-002 clk  in  1  pixel clock; the only clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in  vga_if.in  -  timing plus map rgb stream, before any sprite or text overlay.
REQ-005 out  vga_if.out  -  same stream, registered.
REQ-006 xpos  in  11  player probe column, pixels.
REQ-007 ypos  in  11  player probe row, pixels.
REQ-008 current_pix  out  12  debounced zone code under the player; feeds the dialog stage.
REQ-009 zone_change  out  1  one-cycle pulse when current_pix changes.

Function
REQ-010 out.* SHALL equal in.* delayed exactly 1 clk, for all fields.
REQ-011 xpos/ypos SHALL be latched into probe registers on the vsync rising edge only; mid-frame changes SHALL take effect next frame.
REQ-012 Sample capture: when in.hcount==probe_x, in.vcount==probe_y, !in.hblnk and !in.vblnk, in.rgb SHALL be stored as the frame sample and a captured flag SHALL be set.
REQ-013 Classification: a sample of ZONE_WOMAN (12'h00F), ZONE_WIZARD (12'h0FF) or ZONE_DOOR (12'hFF0) SHALL keep its value; any other value, or no capture in the frame, SHALL become ZONE_NONE (12'h000).
REQ-014 Evaluation SHALL occur on the cycle after the vsync rising edge, once per frame; the captured flag SHALL then clear.
REQ-015 FSM states: LOCKED and PENDING.
REQ-016 In LOCKED with code == current_pix: stay LOCKED, counter=0.
REQ-017 In LOCKED with code != current_pix: candidate=code, counter=1, go to PENDING; if STABLE_FRAMES==1, publish immediately instead.
REQ-018 In PENDING with code == candidate: counter+1; when it reaches STABLE_FRAMES, current_pix<=candidate, zone_change=1 for 1 clk, counter=0, go to LOCKED.
REQ-019 In PENDING with code == current_pix: counter=0, go to LOCKED, no pulse.
REQ-020 In PENDING with any other code: candidate=code, counter=1, stay PENDING.
REQ-021 Counter SHALL be 4 bits and SHALL saturate; it never wraps.
REQ-022 Latency from the first stable frame to the zone_change pulse SHALL be STABLE_FRAMES evaluations.

Reset
REQ-023 On rst: out.* =0, current_pix=ZONE_NONE, zone_change=0, candidate=0, counter=0, probe regs=0, captured=0, state=LOCKED.
REQ-024 Reset mid-frame SHALL discard any pending sample and candidate, with no pulse.

Configuration
REQ-025 Macro ZONE_DEBUG_MARKER_EN: when defined, out.rgb SHALL be forced to 12'hF0F on the probe pixel (same 1-clk latency); when undefined, out.rgb SHALL be a pure delay of in.rgb.

Structure
REQ-026 The ZONE_* codes, the marker colour and the zone_state_t enum SHALL live in vga_pkg.
REQ-027 Sub-module zone_debounce SHALL hold the FSM, candidate and counter; the top holds capture and the pipeline.

Verification
REQ-028 Probe (100,200) on a 12'h00F map pixel for 4 frames -> current_pix=12'h00F after the 4th evaluation, exactly one zone_change pulse.
REQ-029 Wizard code for 3 frames, then 12'h000 -> no publish, state back to LOCKED, no pulse.
REQ-030 Alternating 12'hFF0/12'h0FF each frame -> current_pix stays 12'h000, no pulse.
REQ-031 Probe (900,900), off-screen -> code ZONE_NONE; a locked 12'h0FF returns to 12'h000 after 4 frames.
REQ-032 xpos changed mid-frame -> sample still taken at the old probe, new probe used next frame.
REQ-033 rst asserted during PENDING at counter 3 -> all outputs reset; a following stable code needs 4 full frames; with ZONE_DEBUG_MARKER_EN defined, out.rgb = 12'hF0F at the probe pixel.
